// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote, break detect and FWFT receive FIFO
// Frames are sampled three times around each bit centre; results queue as {perr, ferr, data}.
module uart_rx_os #(
  parameter int OSR         = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       rx_clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       rx,
  input  logic [3:0] length,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       stop2,
  output logic [7:0] rd_data,
  output logic       rd_perr,
  output logic       rd_ferr,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       break_det,
  output logic       busy
);
  localparam int CW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_S0   = CW'(OSR/2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(OSR/2);
  localparam logic [CW-1:0] C_VOTE = CW'(OSR/2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_BREAK
  } state_t;

  state_t           r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_bitn, r_last, w_last;
  logic             r_par_en, r_par_type, r_stop2;
  logic [7:0]       r_data;
  logic             r_pbit, r_perr, r_ferr, r_s0, r_s1, r_break, r_ovr;
  logic             w_rx_s, w_maj, w_vote, w_end, w_exp_par, w_is_break;

  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic [9:0]       w_head;
  logic             w_empty, w_full, w_pop, w_push, w_wr;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_vote     = (r_cnt == C_VOTE);
  assign w_end      = (r_cnt == C_LAST);
  // Upper data bits stay 0, so the full-width reduction covers only the received bits.
  assign w_exp_par  = r_par_type ? ^r_data : ~^r_data;
  assign w_is_break = (r_data == 8'd0) && !r_pbit;

  always_comb begin
    w_last = 3'd7;
    case (length)
      4'd5:    w_last = 3'd4;
      4'd6:    w_last = 3'd5;
      4'd7:    w_last = 3'd6;
      default: w_last = 3'd7;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (rx_en && !w_rx_s) w_next = S_START;
      S_START:  if (w_vote && w_maj) w_next = S_IDLE;
                else if (w_end) w_next = S_DATA;
      S_DATA:   if (w_end && r_bitn == r_last) w_next = r_par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (w_end) w_next = S_STOP1;
      S_STOP1:  if (w_vote && !w_maj && w_is_break) w_next = S_BREAK;
                else if (w_end) w_next = r_stop2 ? S_STOP2 : S_PUSH;
      S_STOP2:  if (w_end) w_next = S_PUSH;
      S_PUSH:   w_next = S_IDLE;
      S_BREAK:  if (w_rx_s) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sync     <= '1;
      r_cnt      <= '0;
      r_bitn     <= '0;
      r_last     <= 3'd7;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_stop2    <= 1'b0;
      r_data     <= '0;
      r_pbit     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_break    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rx};
      if (r_state == S_IDLE || w_next == S_IDLE || w_end ||
          (r_state == S_STOP1 && w_next == S_BREAK))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_S0) r_s0 <= w_rx_s;
      if (r_cnt == C_S1) r_s1 <= w_rx_s;
      r_break <= (r_state == S_STOP1) && (w_next == S_BREAK);
      if (r_state == S_IDLE && w_next == S_START) begin
        r_last     <= w_last;
        r_par_en   <= parity_en;
        r_par_type <= parity_type;
        r_stop2    <= stop2;
        r_data     <= '0;
        r_bitn     <= '0;
        r_pbit     <= 1'b0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
      end
      if (r_state == S_DATA) begin
        if (w_vote) r_data[r_bitn] <= w_maj;
        if (w_end)  r_bitn <= r_bitn + 1'b1;
      end
      if (r_state == S_PARITY && w_vote) begin
        r_pbit <= w_maj;
        r_perr <= (w_maj != w_exp_par);
      end
      if ((r_state == S_STOP1 || r_state == S_STOP2) && w_vote && !w_maj)
        r_ferr <= 1'b1;
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && rd_ready;
  assign w_push  = (r_state == S_PUSH);
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && w_full && !w_pop) r_ovr <= 1'b1;
      else if (ovr_clr)               r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {r_perr, r_ferr, r_data};
  end

  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign rd_valid  = !w_empty;
  assign rd_data   = w_empty ? 8'd0 : w_head[7:0];
  assign rd_ferr   = w_empty ? 1'b0 : w_head[8];
  assign rd_perr   = w_empty ? 1'b0 : w_head[9];
  assign overrun   = r_ovr;
  assign break_det = r_break;
  assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os
module tb_uart_rx_os;
  localparam int OSR = 16;

  logic       rx_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] length = 4'd8;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       stop2 = 1'b0;
  logic       rd_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr, rd_valid, overrun, break_det, busy;

  int n_checks = 0;
  int n_errors = 0;
  int brk_cnt = 0;

  uart_rx_os #(.OSR(OSR), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx), .length(length),
    .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .overrun(overrun), .ovr_clr(ovr_clr),
    .break_det(break_det), .busy(busy)
  );

  always #5 rx_clk = ~rx_clk;

  always @(posedge rx_clk) if (break_det) brk_cnt <= brk_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int k = 0; k < OSR; k++) begin
      rx = (glitch && k == 9) ? ~v : v;
      @(negedge rx_clk);
    end
  endtask

  // gbit: frame bit index (0 = start) that gets a one-cycle inversion near its centre; -1 for none
  task automatic send_frame(input logic [7:0] d, input int len, input bit pen, input logic pbit,
                            input int nstop, input logic stopv, input int gbit);
    drive_bit(1'b0, gbit == 0);
    for (int i = 0; i < len; i++) drive_bit(d[i], gbit == i + 1);
    if (pen) drive_bit(pbit, 1'b0);
    for (int s = 0; s < nstop; s++) drive_bit(stopv, 1'b0);
    rx = 1'b1;
    repeat (32) @(negedge rx_clk);
  endtask

  task automatic set_cfg(input logic [3:0] len, input logic pen, input logic ptype, input logic st2);
    length = len; parity_en = pen; parity_type = ptype; stop2 = st2;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, ".valid"}, rd_valid, 1);
    check({tag, ".data"}, rd_data, d);
    check({tag, ".perr"}, rd_perr, pe);
    check({tag, ".ferr"}, rd_ferr, fe);
    rd_ready = 1'b1;
    @(negedge rx_clk);
    rd_ready = 1'b0;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) begin
        ok = 1'b1;
        return;
      end
      @(negedge rx_clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    repeat (3) @(negedge rx_clk);
    check("reset_outputs", {rd_data, rd_perr, rd_ferr, rd_valid, overrun, break_det, busy}, 0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (4) @(negedge rx_clk);
    check("post_reset_outputs", {rd_data, rd_perr, rd_ferr, rd_valid, overrun, break_det, busy}, 0);

    // 8N1 0x55: busy spans 161 cycles, entry visible the cycle after PUSH
    fork
      send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      begin
        wait_busy(ok);
        check("t1_busy_rise", ok, 1);
        repeat (160) @(negedge rx_clk);
        check("t1_push_busy", busy, 1);
        check("t1_push_valid", rd_valid, 0);
        @(negedge rx_clk);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_valid", rd_valid, 1);
      end
    join
    pop_check("t1", 8'h55, 1'b0, 1'b0);
    check("t1_single_entry", rd_valid, 0);

    // 7E2 with wrong parity, then 5N1 with a low stop bit
    set_cfg(4'd7, 1'b1, 1'b1, 1'b1);
    send_frame(8'h3A, 7, 1'b1, 1'b1, 2, 1'b1, -1);
    set_cfg(4'd5, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1, 1'b0, -1);
    pop_check("t2_par", 8'h3A, 1'b1, 1'b0);
    pop_check("t2_frm", 8'h1F, 1'b0, 1'b1);
    check("t2_empty", rd_valid, 0);

    // short low pulse rejected; single-sample glitch outvoted
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (5) @(negedge rx_clk);
    rx = 1'b1;
    repeat (40) @(negedge rx_clk);
    check("t3_glitch_busy", busy, 0);
    check("t3_glitch_empty", rd_valid, 0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 4);
    pop_check("t3_vote", 8'hA5, 1'b0, 1'b0);

    // overrun on fifth frame, drain, clear
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 8, 1'b0, 1'b0, 1, 1'b1, -1);
      if (i == 4) check("t4_no_ovr_at_full", overrun, 0);
    end
    check("t4_overrun", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_check("t4_drain", 8'(i), 1'b0, 1'b0);
    check("t4_drained", rd_valid, 0);
    check("t4_ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    @(negedge rx_clk);
    ovr_clr = 1'b0;
    check("t4_ovr_clr", overrun, 0);

    // full FIFO with pop in the PUSH cycle: both happen
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t5_full_no_ovr", overrun, 0);
    fork
      send_frame(8'h06, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      begin
        wait_busy(ok);
        check("t5_busy_rise", ok, 1);
        repeat (160) @(negedge rx_clk);
        rd_ready = 1'b1;
        @(negedge rx_clk);
        rd_ready = 1'b0;
        check("t5_push_pop_ovr", overrun, 0);
      end
    join
    pop_check("t5_o2", 8'h02, 1'b0, 1'b0);
    pop_check("t5_o3", 8'h03, 1'b0, 1'b0);
    pop_check("t5_o4", 8'h04, 1'b0, 1'b0);
    pop_check("t5_o6", 8'h06, 1'b0, 1'b0);
    check("t5_empty", rd_valid, 0);

    // line break
    begin
      int brk0;
      brk0 = brk_cnt;
      rx = 1'b0;
      repeat (20 * OSR) @(negedge rx_clk);
      rx = 1'b1;
      repeat (40) @(negedge rx_clk);
      check("t6_break_pulses", brk_cnt - brk0, 1);
      check("t6_break_no_entry", rd_valid, 0);
      check("t6_break_idle", busy, 0);
    end
    send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    pop_check("t6_after", 8'h42, 1'b0, 1'b0);

    // reset in the middle of a data field
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t7_pre_valid", rd_valid, 1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("t7_mid_busy", busy, 1);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("t7_reset_outputs", {rd_data, rd_perr, rd_ferr, rd_valid, overrun, break_det, busy}, 0);
    @(negedge rx_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge rx_clk);
    check("t7_post_empty", rd_valid, 0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    pop_check("t7_after", 8'h3C, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised successor to the team's single-frame UART receiver.
- Oversamples the asynchronous rx line at OSR clocks per bit and takes a 3-sample majority vote at each bit centre. Rejects false start bits and detects line break.
- Received characters, each tagged with parity and framing error flags, go into a first-word-fall-through FIFO with a valid/ready read port.
- Sits between the serial pin and the host-side register/DMA interface.

Parameters:
- OSR, 16, rx_clk cycles per bit; even, >= 8.
- FIFO_DEPTH, 4, number of receive FIFO entries; power of 2, >= 2.
- SYNC_STAGES, 2, input synchroniser flops on rx; >= 2.

Ports:
- rx_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_en  in  1  level; enables detection of new start bits.
- rx  in  1  asynchronous serial input; idle high.
- length  in  4  data bits per frame, 5..8; any other value is treated as 8.
- parity_en  in  1  1 = a parity bit follows the data.
- parity_type  in  1  1 = even, 0 = odd.
- stop2  in  1  1 = two stop bits.
- rd_data  out  8  FIFO head data, right-aligned, unused upper bits 0.
- rd_perr  out  1  parity error flag of the head entry.
- rd_ferr  out  1  framing error flag of the head entry.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pop request.
- overrun  out  1  sticky; a frame was dropped because the FIFO was full.
- ovr_clr  in  1  clears overrun.
- break_det  out  1  one-cycle pulse per detected break.
- busy  out  1  1 while the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM in IDLE, counters 0, synchroniser flops 1, FIFO empty. All outputs 0 during and after reset.
- rx passes through SYNC_STAGES flops to give rx_s; all decisions use rx_s.
- Bit counter cnt runs 0..OSR-1 in every non-IDLE state.
- Sample points are cnt = OSR/2-1, OSR/2, OSR/2+1. The bit value is the majority of the three samples, decided at cnt = OSR/2+1.
- Frame configuration (length, parity_en, parity_type, stop2) is latched on the IDLE->START transition. Changing these inputs mid-frame has no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH, BREAK.
  - IDLE: if rx_en=1 and rx_s=0, go to START with cnt=0. Otherwise stay.
  - START: if the majority is 1, the start bit is a glitch; go to IDLE with no push. Otherwise at cnt = OSR-1 go to DATA.
  - DATA: bits are received LSB first. After `length` bits (at cnt = OSR-1 of the last bit), go to PARITY if parity_en, else STOP1.
  - PARITY: perr = (received bit != expected). Expected bit is ^data for even and ~^data for odd, computed over the `length` data bits only. At cnt = OSR-1 go to STOP1.
  - STOP1: a majority of 0 sets ferr. If, in addition, all data bits are 0 and the parity bit (if enabled) is 0, the frame is a break: go to BREAK immediately after the vote. Otherwise at cnt = OSR-1 go to STOP2 if stop2, else PUSH.
  - STOP2: a majority of 0 sets ferr. At cnt = OSR-1 go to PUSH.
  - PUSH: one cycle. Writes {perr, ferr, data} to the FIFO, then goes to IDLE. The perr/ferr working flags clear on IDLE->START.
  - BREAK: break_det pulses for one cycle on entry. No FIFO push. Stay until rx_s=1, then go to IDLE.
- Back-to-back frames: IDLE detects start by level (rx_s=0), so a start bit that begins during the PUSH cycle is still caught. It is shortened by at most 1 cycle.
- rx_en=0 mid-frame: the current frame completes normally; only new starts are blocked.
- FIFO behaviour:
  - First-word fall-through. rd_valid = not empty. rd_data/rd_perr/rd_ferr show the head entry, and are 0 when empty.
  - A pop occurs when rd_valid & rd_ready.
  - An entry pushed in cycle t is visible with rd_valid=1 at cycle t+1.
- Push when full with no pop in the same cycle: the frame is dropped, overrun is set, and existing contents are unchanged.
- Push and pop in the same cycle while full: both occur, no overrun.
- Pop while empty is ignored.
- overrun clears on ovr_clr=1. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.

Test Plan:
- OSR=16; 8N1 frame 0x55 with rd_ready=1 -> exactly one entry: rd_data=0x55, perr=0, ferr=0. busy=1 for ~161 cycles; rd_valid rises the cycle after PUSH.
- 7E2 frame 0x3A with a wrong parity bit, then 5-bit 0x1F with stop bit=0 -> entry 1: 0x3A, perr=1, ferr=0; entry 2: 0x1F, perr=0, ferr=1.
- rx low for 5 cycles only, then high -> busy returns to 0, no FIFO entry. Separately, a 1-cycle inversion at cnt=OSR/2 of data bit 3 of 0xA5 -> rd_data=0xA5 (majority vote recovers the bit).
- rd_ready=0, send 5 frames 0x01..0x05 (FIFO_DEPTH=4) -> overrun=1 after frame 5. Draining yields 0x01..0x04. ovr_clr clears overrun.
- FIFO full, then drive rd_ready=1 for the PUSH cycle of a 6th frame 0x06 -> no overrun; FIFO order is 0x02,0x03,0x04,0x06.
- rx held low for 20 bit times -> exactly one break_det pulse, no entry. After rx returns high, a following 0x42 frame is received correctly.
- rst_n asserted mid-DATA -> all outputs 0 immediately, FIFO empty. The next full frame is received correctly.
